// File: rtl/score_keeper_pkg.sv
// ---------------------------------------------------------------------------
// score_keeper_pkg
//   Shared definitions for the score keeper slice: game state encoding,
//   default score saturation limit and the 24 MHz cycle-count constants used
//   for 0.1 s / 1 s timing, plus a small 8-bit max helper.
// ---------------------------------------------------------------------------
package score_keeper_pkg;

  // Game state as seen by the display/game stages. 2'b11 is unused and is
  // steered back to IDLE by the FSM.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_OVER = 2'b10
  } state_t;

  // Display stage decodes 0..199 only.
  localparam int MAX_SCORE_DEF = 199;

  // clk_24m cycle counts for common time bases.
  localparam int CYC_100MS = 2_400_000;
  localparam int CYC_1S    = 24_000_000;

  // Width of the alternation timer; holds 0..CYC_1S-1.
  localparam int ALT_W = 25;

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rise_edge_det.sv
// ---------------------------------------------------------------------------
// rise_edge_det
//   One-cycle rising-edge detector for an already-synchronous level input.
//   A level held high produces exactly one rise pulse.
//
//   clk_24m : system clock
//   rst_n   : asynchronous active-low reset (previous-value register -> 0)
//   d       : level input
//   rise    : d & ~previous d (combinational, same cycle as first high sample)
// ---------------------------------------------------------------------------
module rise_edge_det (
  input  logic clk_24m,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic prev_q;

  // NOTE: sequential state is always written with non-blocking (<=) so every
  // register samples the pre-edge values of its inputs.
  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= d;
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/score_keeper.sv
// ---------------------------------------------------------------------------
// score_keeper
//   Tracks pipes passed during a run (saturating at MAX_SCORE), keeps the
//   session best, and after a crash alternates the displayed value between
//   the last score and the best every ALT_TIME cycles.
//
//   Parameters
//     MAX_SCORE : saturation limit for score
//     ALT_TIME  : clk_24m cycles per display phase in OVER
//
//   Ports
//     clk_24m   : 24 MHz system clock
//     rst_n     : asynchronous active-low reset (clears best too)
//     start     : start/restart level, acts on rising edge
//     pipe_pass : pipe cleared level, acts on rising edge
//     crash     : collision flag level
//     num       : value for the seven-segment stage
//     score     : current-run score
//     best      : session best score
//     state     : 00 IDLE, 01 PLAY, 10 OVER
//     new_best  : in OVER, high when the finished run beat the previous best
// ---------------------------------------------------------------------------
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int MAX_SCORE = MAX_SCORE_DEF,
  parameter int ALT_TIME  = CYC_1S
) (
  input  logic       clk_24m,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pipe_pass,
  input  logic       crash,
  output logic [7:0] num,
  output logic [7:0] score,
  output logic [7:0] best,
  output logic [1:0] state,
  output logic       new_best
);

  localparam logic [7:0]       SCORE_LIMIT = 8'(MAX_SCORE);
  localparam logic [ALT_W-1:0] ALT_LAST    = ALT_W'(ALT_TIME - 1);

  state_t           state_q, state_d;
  logic             start_rise, pipe_rise;
  logic [7:0]       score_q, best_q;
  logic             new_best_q;
  logic [ALT_W-1:0] alt_cnt_q;
  logic             show_best_q;   // display select in OVER: 0 score, 1 best

  rise_edge_det u_start_edge (
    .clk_24m (clk_24m),
    .rst_n   (rst_n),
    .d       (start),
    .rise    (start_rise)
  );

  rise_edge_det u_pipe_edge (
    .clk_24m (clk_24m),
    .rst_n   (rst_n),
    .d       (pipe_pass),
    .rise    (pipe_rise)
  );

  // State register.
  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would infer a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_rise) state_d = ST_PLAY;
      ST_PLAY: if (crash)      state_d = ST_OVER;
      ST_OVER: if (start_rise) state_d = ST_PLAY;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Score, best, new-best flag and the OVER alternation timer.
  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      score_q     <= '0;
      best_q      <= '0;
      new_best_q  <= 1'b0;
      alt_cnt_q   <= '0;
      show_best_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_rise) begin
            score_q    <= '0;
            new_best_q <= 1'b0;
          end
        end
        ST_PLAY: begin
          // Crash takes priority over a pipe edge on the same cycle.
          if (crash) begin
            best_q      <= max8(best_q, score_q);
            new_best_q  <= (score_q > best_q);
            alt_cnt_q   <= '0;
            show_best_q <= 1'b0;
          end else if (pipe_rise && (score_q < SCORE_LIMIT)) begin
            score_q <= score_q + 8'd1;
          end
        end
        ST_OVER: begin
          if (start_rise) begin
            score_q     <= '0;
            new_best_q  <= 1'b0;
            alt_cnt_q   <= '0;
            show_best_q <= 1'b0;
          end else if (alt_cnt_q == ALT_LAST) begin
            alt_cnt_q   <= '0;
            show_best_q <= ~show_best_q;
          end else begin
            alt_cnt_q <= alt_cnt_q + 1'b1;
          end
        end
        default: ;  // illegal encoding: FSM returns to IDLE, data untouched
      endcase
    end
  end

  // Display mux.
  always_comb begin
    num = best_q;
    case (state_q)
      ST_IDLE: num = best_q;
      ST_PLAY: num = score_q;
      ST_OVER: num = show_best_q ? best_q : score_q;
      default: num = best_q;
    endcase
  end

  assign score    = score_q;
  assign best     = best_q;
  assign state    = state_q;
  assign new_best = new_best_q;

endmodule

// File: tb/tb_score_keeper.sv
// ---------------------------------------------------------------------------
// tb_score_keeper
//   Randomized and directed checks of score_keeper against a behavioural
//   model of the game rules (ALT_TIME shortened to 10 cycles).
// ---------------------------------------------------------------------------
module tb_score_keeper;

  localparam int TB_MAX = 199;
  localparam int TB_ALT = 10;

  logic       clk_24m = 1'b0;
  logic       rst_n   = 1'b0;
  logic       start   = 1'b0;
  logic       pipe_pass = 1'b0;
  logic       crash   = 1'b0;
  logic [7:0] num, score, best;
  logic [1:0] state;
  logic       new_best;

  int checks   = 0;
  int failures = 0;

  // Behavioural model.
  logic [1:0] m_state;
  logic [7:0] m_score, m_best;
  logic       m_nb;
  int         m_over;     // cycles spent in OVER since the crash
  logic       m_ps, m_pp; // previous start / pipe_pass samples

  score_keeper #(.MAX_SCORE(TB_MAX), .ALT_TIME(TB_ALT)) dut (
    .clk_24m   (clk_24m),
    .rst_n     (rst_n),
    .start     (start),
    .pipe_pass (pipe_pass),
    .crash     (crash),
    .num       (num),
    .score     (score),
    .best      (best),
    .state     (state),
    .new_best  (new_best)
  );

  always #5 clk_24m = ~clk_24m;

  task automatic model_reset();
    m_state = 2'b00; m_score = 8'd0; m_best = 8'd0; m_nb = 1'b0;
    m_over = 0; m_ps = 1'b0; m_pp = 1'b0;
  endtask

  function automatic logic [7:0] model_num();
    case (m_state)
      2'b00:   return m_best;
      2'b01:   return m_score;
      default: return (((m_over / TB_ALT) % 2) == 1) ? m_best : m_score;
    endcase
  endfunction

  // Advance the model by the rules for the inputs currently applied, then
  // let the DUT take one clock edge; returns 1 ns after the edge.
  task automatic tick();
    logic rs, rp;
    rs = start & ~m_ps;
    rp = pipe_pass & ~m_pp;
    m_ps = start;
    m_pp = pipe_pass;
    case (m_state)
      2'b00: if (rs) begin m_state = 2'b01; m_score = 8'd0; m_nb = 1'b0; end
      2'b01: begin
        if (crash) begin
          m_state = 2'b10;
          m_nb    = (m_score > m_best);
          if (m_score > m_best) m_best = m_score;
          m_over  = 0;
        end else if (rp && m_score < TB_MAX) begin
          m_score = m_score + 8'd1;
        end
      end
      default: begin
        if (rs) begin m_state = 2'b01; m_score = 8'd0; m_nb = 1'b0; end
        else m_over++;
      end
    endcase
    @(posedge clk_24m);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; pipe_pass = 1'b0; crash = 1'b0;
    repeat (3) @(posedge clk_24m);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic start_pulse();
    start = 1'b1; tick();
    start = 1'b0; tick();
  endtask

  task automatic pipe_pulses(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      pipe_pass = 1'b1; repeat (hi) tick();
      pipe_pass = 1'b0; repeat (lo) tick();
    end
  endtask

  task automatic crash_pulse();
    crash = 1'b1; tick();
    crash = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (20) tick();
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (num !== 8'd0)    begin failures++; $display("FAIL reset_num: got %0d expected 0", num); end
    checks++; if (score !== 8'd0)  begin failures++; $display("FAIL reset_score: got %0d expected 0", score); end
    checks++; if (best !== 8'd0)   begin failures++; $display("FAIL reset_best: got %0d expected 0", best); end
    checks++; if (new_best !== 1'b0) begin failures++; $display("FAIL reset_new_best: got %0d expected 0", new_best); end
  endtask

  task automatic test_count();
    start_pulse();
    checks++; if (state !== 2'b01) begin failures++; $display("FAIL play_state: got %0d expected 1", state); end
    for (int i = 0; i < 5; i++) begin
      pipe_pass = 1'b1;
      checks++; if (score !== 8'(i)) begin failures++; $display("FAIL pre_rise_score: got %0d expected %0d", score, i); end
      tick();
      checks++; if (score !== 8'(i + 1)) begin failures++; $display("FAIL rise_latency: got %0d expected %0d", score, i + 1); end
      repeat (2) tick();
      pipe_pass = 1'b0; repeat (2) tick();
      checks++; if (score !== 8'(i + 1)) begin failures++; $display("FAIL held_level: got %0d expected %0d", score, i + 1); end
    end
    checks++; if (num !== 8'd5) begin failures++; $display("FAIL play_num: got %0d expected 5", num); end
  endtask

  task automatic check_alternation(input string tag, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      checks++;
      if (num !== model_num()) begin
        failures++;
        $display("FAIL %s cycle %0d: num got %0d expected %0d", tag, c, num, model_num());
      end
      tick();
    end
  endtask

  task automatic test_crash_alt();
    crash_pulse();
    checks++; if (state !== 2'b10) begin failures++; $display("FAIL over_state: got %0d expected 2", state); end
    checks++; if (best !== 8'd5)   begin failures++; $display("FAIL over_best: got %0d expected 5", best); end
    checks++; if (new_best !== 1'b1) begin failures++; $display("FAIL over_new_best: got %0d expected 1", new_best); end
    check_alternation("alt_first", 40);
    start_pulse();
    pipe_pulses(3, 3, 2);
    crash_pulse();
    checks++; if (score !== 8'd3)  begin failures++; $display("FAIL run2_score: got %0d expected 3", score); end
    checks++; if (best !== 8'd5)   begin failures++; $display("FAIL run2_best: got %0d expected 5", best); end
    checks++; if (new_best !== 1'b0) begin failures++; $display("FAIL run2_new_best: got %0d expected 0", new_best); end
    // Phase boundaries: score for the first ALT_TIME cycles, then best.
    repeat (TB_ALT - 1) tick();
    checks++; if (num !== 8'd3) begin failures++; $display("FAIL phase_end_score: got %0d expected 3", num); end
    tick();
    checks++; if (num !== 8'd5) begin failures++; $display("FAIL phase_start_best: got %0d expected 5", num); end
    check_alternation("alt_second", 30);
  endtask

  task automatic test_saturate();
    start_pulse();
    pipe_pulses(205, 1, 1);
    checks++; if (score !== 8'd199) begin failures++; $display("FAIL saturate_score: got %0d expected 199", score); end
    crash_pulse();
    checks++; if (best !== 8'd199) begin failures++; $display("FAIL saturate_best: got %0d expected 199", best); end
    for (int c = 0; c < 25; c++) begin
      checks++; if (num !== 8'd199) begin failures++; $display("FAIL saturate_num cycle %0d: got %0d expected 199", c, num); end
      tick();
    end
  endtask

  task automatic test_crash_wins();
    start_pulse();
    pipe_pulses(7, 1, 1);
    pipe_pass = 1'b1; crash = 1'b1; tick();
    pipe_pass = 1'b0; crash = 1'b0; tick();
    checks++; if (score !== 8'd7)  begin failures++; $display("FAIL crash_wins_score: got %0d expected 7", score); end
    checks++; if (state !== 2'b10) begin failures++; $display("FAIL crash_wins_state: got %0d expected 2", state); end
    pipe_pulses(3, 1, 1);
    crash = 1'b1; tick(); crash = 1'b0; tick();
    checks++; if (score !== 8'd7 || state !== 2'b10) begin
      failures++; $display("FAIL over_ignores_inputs: score %0d state %0d expected 7/2", score, state);
    end
    start_pulse();
    pipe_pulses(2, 1, 1);
    start_pulse();
    checks++; if (score !== 8'd2 || state !== 2'b01) begin
      failures++; $display("FAIL play_ignores_start: score %0d state %0d expected 2/1", score, state);
    end
    crash_pulse();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      start     = ($urandom_range(0, 29) == 0);
      pipe_pass = $urandom_range(0, 1) == 1;
      crash     = ($urandom_range(0, 39) == 0);
      tick();
      checks++;
      if ({state, num, score, best, new_best} !== {m_state, model_num(), m_score, m_best, m_nb}) begin
        failures++;
        $display("FAIL random cycle %0d: st %0d num %0d sc %0d best %0d nb %0d expected st %0d num %0d sc %0d best %0d nb %0d",
                 c, state, num, score, best, new_best, m_state, model_num(), m_score, m_best, m_nb);
      end
    end
    start = 1'b0; pipe_pass = 1'b0; crash = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    start_pulse();
    pipe_pulses(10, 1, 1);
    crash_pulse();
    tick();
    start_pulse();
    pipe_pulses(42, 1, 1);
    checks++; if (score !== 8'd42 || best !== 8'd10) begin
      failures++; $display("FAIL pre_reset: score %0d best %0d expected 42/10", score, best);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({state, num, score, best, new_best} !== 27'd0) begin
      failures++; $display("FAIL async_reset: st %0d num %0d sc %0d best %0d nb %0d expected all 0",
                           state, num, score, best, new_best);
    end
    @(posedge clk_24m); #1;
    rst_n = 1'b1;
    model_reset();
    start_pulse();
    pipe_pulses(1, 1, 1);
    checks++; if (score !== 8'd1 || best !== 8'd0) begin
      failures++; $display("FAIL post_reset_run: score %0d best %0d expected 1/0", score, best);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_count();
    test_crash_alt();
    test_saturate();
    test_crash_wins();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
